keypad_scan_fifo: RTL and testbench



---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_scan_fifo_sync_fifo.sv | 78 +++++++
 rtl/keypad_scan_fifo.sv | 258 +++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: scan FSM states, the
// frame-candidate encoding with its NONE value, and a clog2-style width function.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EVAL = 2'd2
  } scan_state_e;

  // Wide enough for the largest supported 8x8 matrix.
  localparam int MAX_CODE_W = 6;

  typedef struct packed {
    logic                  valid;
    logic [MAX_CODE_W-1:0] code;
  } cand_t;

  localparam cand_t CAND_NONE = '{valid: 1'b0, code: 6'd0};

  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_sync_fifo.sv
// Shift-register FIFO with a registered first-word-fall-through head,
// registered count/full/empty. Simultaneous push and pop is legal when full.
module sync_fifo
  import keypad_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  DEPTH = 4,
  localparam int AW    = clog2_w(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r   [DEPTH];
  logic [WIDTH-1:0] mem_n_s [DEPTH];
  logic [CNT_W-1:0] count_r, count_n_s;
  logic             valid_r, full_r;
  logic             do_pop_s, do_push_s;
  logic [AW-1:0]    wr_idx_s;

  // Next storage contents: shift toward the head on pop, write at the tail on push.
  always_comb begin
    do_pop_s  = rd_en & valid_r;
    do_push_s = wr_en & (~full_r | do_pop_s);
    if (do_pop_s) begin
      wr_idx_s = AW'(count_r - CNT_W'(1));
    end else begin
      wr_idx_s = AW'(count_r);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push_s && (wr_idx_s == AW'(i))) begin
        mem_n_s[i] = wr_data;
      end else if (do_pop_s) begin
        mem_n_s[i] = (i < DEPTH - 1) ? mem_r[(i + 1) % DEPTH] : '0;
      end else begin
        mem_n_s[i] = mem_r[i];
      end
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_n_s = count_r + CNT_W'(1);
      2'b01:   count_n_s = count_r - CNT_W'(1);
      default: count_n_s = count_r;
    endcase
  end

  // Storage and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      count_r <= '0;
      valid_r <= 1'b0;
      full_r  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_n_s[i];
      end
      count_r <= count_n_s;
      valid_r <= (count_n_s != '0);
      full_r  <= (count_n_s == CNT_W'(DEPTH));
    end
  end

  assign rd_data = mem_r[0];
  assign empty   = ~valid_r;
  assign full    = full_r;
  assign count   = count_r;

endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner with synchroniser, frame debounce and key-code FIFO.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int  ROWS          = 4,
  parameter int  COLS          = 4,
  parameter int  SCAN_DIV      = 1000,
  parameter int  DEBOUNCE      = 3,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  REPEAT_FRAMES = 32,
  localparam int CODE_W        = clog2_w(ROWS * COLS),
  localparam int CNT_W         = clog2_w(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_drive,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int ROW_W = clog2_w(ROWS);
  localparam int COL_W = clog2_w(COLS);
  localparam int DIV_W = clog2_w(SCAN_DIV);

  scan_state_e     state_r, state_n_s;
  logic [ROW_W-1:0] row_r, row_n_s;
  logic [DIV_W-1:0] div_r, div_n_s;
  logic [ROWS-1:0]  row_drive_r;
  logic             sample_s;
  logic [COLS-1:0]  col_meta_r, col_sync_r;
  logic             hit_s;
  logic [COL_W-1:0] hit_col_s;
  cand_t            frame_cand_r, frame_cand_n_s, last_cand_r;
  logic [3:0]       stable_cnt_r, stable_cnt_n_s;
  logic             same_s, stable_s, accept_s;
  logic             reported_r, reported_n_s;
  logic             rep_s, push_s, drop_s;
  logic             fifo_empty_s, fifo_full_s, key_valid_s;
  logic             overflow_r;

  // Scan FSM next state: walk rows, sample on the last cycle of each slot.
  always_comb begin
    state_n_s = state_r;
    row_n_s   = row_r;
    div_n_s   = div_r;
    sample_s  = 1'b0;
    if (!en) begin
      state_n_s = IDLE;
      row_n_s   = '0;
      div_n_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_n_s = SCAN;
          row_n_s   = '0;
          div_n_s   = '0;
        end
        SCAN: begin
          if (div_r == DIV_W'(SCAN_DIV - 1)) begin
            sample_s = 1'b1;
            div_n_s  = '0;
            if (row_r == ROW_W'(ROWS - 1)) begin
              state_n_s = EVAL;
              row_n_s   = '0;
            end else begin
              row_n_s = row_r + ROW_W'(1);
            end
          end else begin
            div_n_s = div_r + DIV_W'(1);
          end
        end
        EVAL: begin
          state_n_s = SCAN;
          row_n_s   = '0;
          div_n_s   = '0;
        end
        default: begin
          state_n_s = IDLE;
          row_n_s   = '0;
          div_n_s   = '0;
        end
      endcase
    end
  end

  // Scan state and registered one-hot row drive aligned with the slot counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      row_r       <= '0;
      div_r       <= '0;
      row_drive_r <= '0;
    end else begin
      state_r     <= state_n_s;
      row_r       <= row_n_s;
      div_r       <= div_n_s;
      row_drive_r <= (state_n_s == SCAN) ? ({{(ROWS-1){1'b0}}, 1'b1} << row_n_s) : '0;
    end
  end

  // Two-flop synchroniser for the asynchronous column returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_r <= '0;
      col_sync_r <= '0;
    end else begin
      col_meta_r <= col_in;
      col_sync_r <= col_meta_r;
    end
  end

  // Frame candidate: rows arrive in ascending order, so the first hit is the lowest code.
  always_comb begin
    hit_s     = |col_sync_r;
    hit_col_s = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      hit_col_s = col_sync_r[c] ? COL_W'(c) : hit_col_s;
    end
    if (state_r != SCAN) begin
      frame_cand_n_s = CAND_NONE;
    end else if (sample_s && hit_s && !frame_cand_r.valid) begin
      frame_cand_n_s.valid = 1'b1;
      frame_cand_n_s.code  = MAX_CODE_W'(int'(row_r) * COLS + int'(hit_col_s));
    end else begin
      frame_cand_n_s = frame_cand_r;
    end
  end

  // Debounce decision for the frame just completed.
  always_comb begin
    same_s = (frame_cand_r == last_cand_r);
    if (!same_s) begin
      stable_cnt_n_s = 4'd1;
    end else if (stable_cnt_r == 4'd15) begin
      stable_cnt_n_s = 4'd15;
    end else begin
      stable_cnt_n_s = stable_cnt_r + 4'd1;
    end
    stable_s = (stable_cnt_n_s >= 4'(DEBOUNCE));
    accept_s = (state_r == EVAL) && frame_cand_r.valid && stable_s && !reported_r;
    if (accept_s) begin
      reported_n_s = 1'b1;
    end else if (!frame_cand_r.valid && stable_s) begin
      reported_n_s = 1'b0;
    end else begin
      reported_n_s = reported_r;
    end
  end

  // Debounce state: updated once per frame, cleared whenever scanning is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cand_r <= CAND_NONE;
      last_cand_r  <= CAND_NONE;
      stable_cnt_r <= 4'd0;
      reported_r   <= 1'b0;
    end else begin
      frame_cand_r <= frame_cand_n_s;
      if (state_r == IDLE) begin
        last_cand_r  <= CAND_NONE;
        stable_cnt_r <= 4'd0;
        reported_r   <= 1'b0;
      end else if (state_r == EVAL) begin
        last_cand_r  <= frame_cand_r;
        stable_cnt_r <= stable_cnt_n_s;
        reported_r   <= reported_n_s;
      end else begin
        last_cand_r  <= last_cand_r;
        stable_cnt_r <= stable_cnt_r;
        reported_r   <= reported_r;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = clog2_w(REPEAT_FRAMES);
  logic [RPT_W-1:0] rep_cnt_r;
  logic             rep_active_r;

  // Repeat fires after REPEAT_FRAMES further stable frames of the accepted key.
  always_comb begin
    rep_s = (state_r == EVAL) && rep_active_r && same_s &&
            (rep_cnt_r == RPT_W'(REPEAT_FRAMES - 1));
  end

  // Repeat counter; any candidate change ends the repeat run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_r    <= '0;
      rep_active_r <= 1'b0;
    end else if (state_r == IDLE) begin
      rep_cnt_r    <= '0;
      rep_active_r <= 1'b0;
    end else if (state_r == EVAL) begin
      if (accept_s || rep_s) begin
        rep_cnt_r    <= '0;
        rep_active_r <= 1'b1;
      end else if (!same_s) begin
        rep_cnt_r    <= '0;
        rep_active_r <= 1'b0;
      end else begin
        rep_cnt_r    <= rep_cnt_r + RPT_W'(1);
        rep_active_r <= rep_active_r;
      end
    end else begin
      rep_cnt_r    <= rep_cnt_r;
      rep_active_r <= rep_active_r;
    end
  end
`else
  assign rep_s = 1'b0;
`endif

  assign push_s = accept_s | rep_s;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_data (frame_cand_r.code[CODE_W-1:0]),
    .rd_en   (key_ready),
    .rd_data (key_code),
    .empty   (fifo_empty_s),
    .full    (fifo_full_s),
    .count   (fifo_count)
  );

  assign key_valid_s = ~fifo_empty_s;
  assign drop_s      = push_s & fifo_full_s & ~(key_ready & key_valid_s);

  // Sticky overflow; a dropped push outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign row_drive = row_drive_r;
  assign key_valid = key_valid_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: directed key presses on a modelled 4x4
// matrix; expected codes are queued at stimulus time and checked on each pop.
module tb_keypad_scan_fifo;

  logic        clk = 1'b0;
  logic        reset, en, key_ready, clr_overflow;
  logic [3:0]  col_in, row_drive, key_code;
  logic        key_valid, overflow;
  logic [2:0]  fifo_count;
  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_v;
  int          n_checks = 0;
  int          n_pass = 0;
  int          found;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .ROWS          (4),
    .COLS          (4),
    .SCAN_DIV      (4),
    .DEBOUNCE      (3),
    .FIFO_DEPTH    (4),
    .REPEAT_FRAMES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .col_in       (col_in),
    .row_drive    (row_drive),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Keypad model: a pressed key connects its row drive to its column.
  always_comb begin
    col_in = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_drive[r]) col_in = col_in | keys[r*4 +: 4];
    end
  end

  // Monitor: every accepted handshake must match the next expected code.
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got key_code %0d, expected no entry", key_code);
      end else begin
        exp_v = exp_q.pop_front();
        if (key_code === exp_v) n_pass++;
        else $display("FAIL pop_code: got %0d expected %0d", key_code, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns in the EVAL cycle ending the n-th frame (row 3 drive -> no drive).
  task automatic wait_frames(input int n);
    int seen = 0;
    int cyc = 0;
    logic prev;
    prev = row_drive[3];
    while (seen < n && cyc < 20 * n + 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (prev && row_drive == 4'd0) seen++;
      prev = row_drive[3];
    end
    if (seen < n) begin
      n_checks++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", seen, n);
    end
  endtask

  task automatic press(input int k, input int hold, input int rel);
    keys = 16'd0;
    keys[k] = 1'b1;
    wait_frames(hold);
    keys = 16'd0;
    wait_frames(rel);
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; key_ready = 1'b0; clr_overflow = 1'b0; keys = 16'd0;
    cycles(3);
    chk("rst_row_drive", row_drive, 4'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_code", key_code, 4'd0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    en = 1'b1;
    wait_frames(1);

    // Single press of row 2 / col 1.
    exp_q.push_back(4'd9);
    press(9, 6, 0);
    cycles(2);
    chk("single_count", fifo_count, 3'd1);
    chk("single_valid", key_valid, 1'b1);
    chk("single_code", key_code, 4'd9);
    wait_frames(4);
    pulse_ready();
    chk("single_valid_after_pop", key_valid, 1'b0);
    chk("single_count_after_pop", fifo_count, 3'd0);

    pulse_ready();
    chk("empty_ready_count", fifo_count, 3'd0);
    chk("empty_ready_valid", key_valid, 1'b0);

    // Bounce: never stable long enough.
    press(9, 2, 4);
    press(9, 2, 4);
    chk("bounce_count", fifo_count, 3'd0);

    // Priority: keys 3 and 4 together, then 4 alone.
    exp_q.push_back(4'd3);
    keys = 16'd0; keys[3] = 1'b1; keys[4] = 1'b1;
    wait_frames(5);
    keys = 16'd0; keys[4] = 1'b1;
    wait_frames(5);
    chk("prio_count", fifo_count, 3'd1);
    chk("prio_code", key_code, 4'd3);
    keys = 16'd0;
    wait_frames(4);
    chk("prio_count_after_release", fifo_count, 3'd1);
    pulse_ready();
    chk("prio_count_drained", fifo_count, 3'd0);

    // Overflow: six presses into a four-entry FIFO.
    for (int k = 1; k <= 4; k++) exp_q.push_back(4'(k));
    for (int k = 1; k <= 6; k++) press(k, 4, 4);
    chk("ovf_count", fifo_count, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head", key_code, 4'd1);
    key_ready = 1'b1;
    cycles(6);
    key_ready = 1'b0;
    chk("ovf_drained", fifo_count, 3'd0);
    chk("ovf_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    cycles(1);
    clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);

    // Long hold with the consumer always ready.
    key_ready = 1'b1;
    exp_q.push_back(4'd5);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd5);
`endif
    press(5, 19, 4);
    cycles(3);
    key_ready = 1'b0;
    chk("hold_all_delivered", exp_q.size(), 0);

    // Asynchronous reset mid-scan with two entries queued.
    press(2, 4, 4);
    press(7, 4, 4);
    chk("pre_reset_count", fifo_count, 3'd2);
    cycles(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_row_drive", row_drive, 4'd0);
    chk("mid_rst_key_valid", key_valid, 1'b0);
    chk("mid_rst_fifo_count", fifo_count, 3'd0);
    chk("mid_rst_overflow", overflow, 1'b0);
    cycles(2);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 3 && found == 0; i++) begin
      @(posedge clk);
      #1;
      if (row_drive == 4'b0001) found = 1;
    end
    chk("row0_after_reset", row_drive, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
